// File: rtl/seg_scan_ctrl.sv
// Seven-segment scan scheduler: shares one bcd7seg decoder across NDIG digits.
// Optional per-digit decimal point enabled by defining SEG_SCAN_DP_EN.
module seg_scan_ctrl #(
   parameter int unsigned NDIG     = 8,
   parameter int unsigned SHOW_CYC = 50000,
   parameter int unsigned GAP_CYC  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     scan_en,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [$clog2(NDIG)-1:0]  wr_addr,
   input  logic [3:0]               wr_data,
   input  logic                     wr_blank,
`ifdef SEG_SCAN_DP_EN
   input  logic                     wr_dp,
   output logic                     seg_dp,
`endif
   output logic [3:0]               dec_b,
   input  logic [6:0]               dec_h,
   output logic [6:0]               seg_out,
   output logic [NDIG-1:0]          digit_sel
);

   localparam int unsigned AW   = $clog2(NDIG);
   localparam int unsigned CMAX = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
   localparam int unsigned CW   = $clog2(CMAX);
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYC - 1);
   localparam logic [CW-1:0] SHOW_LAST = CW'(SHOW_CYC - 1);
   localparam logic [6:0]    SEG_OFF   = 7'h7F;

   typedef enum logic [1:0] {IDLE, GAP, SHOW} state_t;

   state_t                 state, state_nxt;
   logic [CW-1:0]          cnt, cnt_nxt;
   logic [AW-1:0]          idx, idx_nxt;
   logic [NDIG-1:0][3:0]   nib;
   logic [NDIG-1:0]        blank;
   logic                   wr_fire;
   logic                   dec_load;
   logic [AW-1:0]          dec_addr;
   logic [3:0]             dec_b_nxt;
   logic [6:0]             seg_nxt;
   logic [NDIG-1:0]        sel_nxt;
`ifdef SEG_SCAN_DP_EN
   logic [NDIG-1:0]        dp;
   logic                   seg_dp_nxt;
`endif

   // The lit digit's entry is frozen for the whole SHOW slot.
   always_comb begin
      wr_ready = !((state == SHOW) && (wr_addr == idx));
   end

   assign wr_fire = wr_valid & wr_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         nib   <= '0;
         blank <= '1;
`ifdef SEG_SCAN_DP_EN
         dp    <= '0;
`endif
      end else if (wr_fire) begin
         nib[wr_addr]   <= wr_data;
         blank[wr_addr] <= wr_blank;
`ifdef SEG_SCAN_DP_EN
         dp[wr_addr]    <= wr_dp;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      idx_nxt   = idx;
      dec_load  = 1'b0;
      dec_addr  = idx;
      dec_b_nxt = dec_b;
      seg_nxt   = seg_out;
      sel_nxt   = digit_sel;
`ifdef SEG_SCAN_DP_EN
      seg_dp_nxt = seg_dp;
`endif
      case (state)
         IDLE: begin
            idx_nxt = '0;
            cnt_nxt = '0;
            seg_nxt = SEG_OFF;
            sel_nxt = '1;
`ifdef SEG_SCAN_DP_EN
            seg_dp_nxt = 1'b1;
`endif
            if (scan_en) begin
               state_nxt = GAP;
               dec_load  = 1'b1;
               dec_addr  = '0;
            end
         end
         GAP: begin
            // Reloading every GAP cycle picks up writes to the pending digit.
            dec_load = 1'b1;
            dec_addr = idx;
            if (cnt == GAP_LAST) begin
               state_nxt = SHOW;
               cnt_nxt   = '0;
               seg_nxt   = blank[idx] ? SEG_OFF : dec_h;
               sel_nxt   = blank[idx] ? '1 : ~(NDIG'(1) << idx);
`ifdef SEG_SCAN_DP_EN
               seg_dp_nxt = blank[idx] ? 1'b1 : ~dp[idx];
`endif
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         SHOW: begin
            if (cnt == SHOW_LAST) begin
               state_nxt = GAP;
               cnt_nxt   = '0;
               idx_nxt   = idx + AW'(1);
               dec_load  = 1'b1;
               dec_addr  = idx + AW'(1);
               seg_nxt   = SEG_OFF;
               sel_nxt   = '1;
`ifdef SEG_SCAN_DP_EN
               seg_dp_nxt = 1'b1;
`endif
            end else begin
               cnt_nxt = cnt + CW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (!scan_en) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
         idx_nxt   = '0;
         dec_load  = 1'b0;
         seg_nxt   = SEG_OFF;
         sel_nxt   = '1;
`ifdef SEG_SCAN_DP_EN
         seg_dp_nxt = 1'b1;
`endif
      end

      // Forward a same-edge write so the decoder sees the newest nibble.
      if (dec_load) begin
         dec_b_nxt = (wr_fire && (wr_addr == dec_addr)) ? wr_data : nib[dec_addr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         idx       <= '0;
         dec_b     <= '0;
         seg_out   <= SEG_OFF;
         digit_sel <= '1;
`ifdef SEG_SCAN_DP_EN
         seg_dp    <= 1'b1;
`endif
      end else begin
         cnt       <= cnt_nxt;
         idx       <= idx_nxt;
         dec_b     <= dec_b_nxt;
         seg_out   <= seg_nxt;
         digit_sel <= sel_nxt;
`ifdef SEG_SCAN_DP_EN
         seg_dp    <= seg_dp_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NDIG=8, SHOW_CYC=4, GAP_CYC=1.
module tb_seg_scan_ctrl;

   localparam int NDIG  = 8;
   localparam int SHOW  = 4;
   localparam int GAP   = 1;
   localparam int P     = SHOW + GAP;
   localparam int FRAME = NDIG * P;

   typedef struct {
      logic [2:0] addr;
      logic [3:0] data;
      logic       blank;
      logic [7:0] exp_sel;
      logic [6:0] exp_seg;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n, scan_en, wr_valid, wr_ready, wr_blank;
   logic [2:0] wr_addr;
   logic [3:0] wr_data, dec_b;
   logic [6:0] dec_h, seg_out;
   logic [7:0] digit_sel;
`ifdef SEG_SCAN_DP_EN
   logic       wr_dp, seg_dp;
   assign wr_dp = 1'b0;
`endif

   always #5 clk = ~clk;

   // Active-low gfedcba patterns of the shared decoder.
   function automatic logic [6:0] seg_tab(input logic [3:0] v);
      case (v)
         4'h0: seg_tab = 7'h40; 4'h1: seg_tab = 7'h79; 4'h2: seg_tab = 7'h24; 4'h3: seg_tab = 7'h30;
         4'h4: seg_tab = 7'h19; 4'h5: seg_tab = 7'h12; 4'h6: seg_tab = 7'h02; 4'h7: seg_tab = 7'h78;
         4'h8: seg_tab = 7'h00; 4'h9: seg_tab = 7'h10; 4'hA: seg_tab = 7'h08; 4'hB: seg_tab = 7'h03;
         4'hC: seg_tab = 7'h46; 4'hD: seg_tab = 7'h21; 4'hE: seg_tab = 7'h06; default: seg_tab = 7'h0E;
      endcase
   endfunction

   assign dec_h = seg_tab(dec_b);

   seg_scan_ctrl #(.NDIG(NDIG), .SHOW_CYC(SHOW), .GAP_CYC(GAP)) dut (
      .clk(clk), .rst_n(rst_n), .scan_en(scan_en),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_blank(wr_blank),
`ifdef SEG_SCAN_DP_EN
      .wr_dp(wr_dp), .seg_dp(seg_dp),
`endif
      .dec_b(dec_b), .dec_h(dec_h), .seg_out(seg_out), .digit_sel(digit_sel)
   );

   int n_vec = 0;
   int n_err = 0;

   // Reference model: scan position is derived from edges since scan_en rose.
   bit         m_run;
   int         m_n;
   logic       m_blank [NDIG];
   logic [3:0] m_data  [NDIG];
   logic       cap_b;
   logic [3:0] cap_d;
   vec_t       vecs [NDIG];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit cur_show(output int dig);
      int m;
      dig = 0;
      if (!m_run || m_n < 1) return 1'b0;
      m   = m_n - 1;
      dig = (m / P) % NDIG;
      return (m % P) >= GAP;
   endfunction

   task automatic model_reset();
      m_run = 1'b0; m_n = 0; cap_b = 1'b1; cap_d = '0;
      for (int i = 0; i < NDIG; i++) begin
         m_blank[i] = 1'b1;
         m_data[i]  = '0;
      end
   endtask

   task automatic step(output bit acc);
      bit         show;
      int         dig;
      logic       rdy;
      logic [7:0] esel;
      logic [6:0] eseg;
      show = cur_show(dig);
      rdy  = !(show && (wr_addr == 3'(dig)));
      chk("wr_ready", 32'(wr_ready), 32'(rdy));
      acc = wr_valid && rdy;
      @(posedge clk);
      if (!scan_en) begin m_run = 1'b0; m_n = 0; end
      else begin m_run = 1'b1; m_n++; end
      show = cur_show(dig);
      if (show && ((m_n - 1) % P) == GAP) begin
         cap_b = m_blank[dig];
         cap_d = m_data[dig];
      end
      if (acc) begin
         m_blank[wr_addr] = wr_blank;
         m_data[wr_addr]  = wr_data;
      end
      #1;
      if (show && !cap_b) begin
         esel = ~(8'd1 << dig);
         eseg = seg_tab(cap_d);
      end else begin
         esel = 8'hFF;
         eseg = 7'h7F;
      end
      chk("digit_sel", 32'(digit_sel), 32'(esel));
      chk("seg_out", 32'(seg_out), 32'(eseg));
      if (m_run && m_n >= 1 && !show) chk("dec_b", 32'(dec_b), 32'(m_data[dig]));
   endtask

   task automatic tick();
      bit a;
      step(a);
   endtask

   task automatic seek_show(input int d);
      int  dig;
      bit  s;
      s = cur_show(dig);
      for (int k = 0; k < 2 * FRAME && !(s && dig == d); k++) begin
         tick();
         s = cur_show(dig);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      bit acc;
      int held;
      rst_n = 1'b1; scan_en = 1'b0; wr_valid = 1'b0;
      wr_addr = '0; wr_data = '0; wr_blank = 1'b0;
      for (int i = 0; i < NDIG; i++) begin
         vecs[i].addr  = 3'(i);
         vecs[i].data  = 4'(i);
         vecs[i].blank = 1'b0;
      end
      vecs[0].exp_sel = 8'hFE; vecs[0].exp_seg = 7'h40;
      vecs[1].exp_sel = 8'hFD; vecs[1].exp_seg = 7'h79;
      vecs[2].exp_sel = 8'hFB; vecs[2].exp_seg = 7'h24;
      vecs[3].exp_sel = 8'hF7; vecs[3].exp_seg = 7'h30;
      vecs[4].exp_sel = 8'hEF; vecs[4].exp_seg = 7'h19;
      vecs[5].exp_sel = 8'hDF; vecs[5].exp_seg = 7'h12;
      vecs[6].exp_sel = 8'hBF; vecs[6].exp_seg = 7'h02;
      vecs[7].exp_sel = 8'h7F; vecs[7].exp_seg = 7'h78;
      model_reset();

      // Reset values
      #2 rst_n = 1'b0;
      #1;
      chk("rst_sel", 32'(digit_sel), 32'h0FF);
      chk("rst_seg", 32'(seg_out), 32'h07F);
      chk("rst_ready", 32'(wr_ready), 32'h1);
      chk("rst_dec_b", 32'(dec_b), 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      // All blank: a full frame stays dark
      scan_en = 1'b1;
      repeat (FRAME + 5) tick();

      // Single digit 3 = 5
      scan_en = 1'b0;
      tick();
      wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 4'h5; wr_blank = 1'b0;
      tick();
      wr_valid = 1'b0;
      scan_en  = 1'b1;
      seek_show(3);
      chk("slot3_sel", 32'(digit_sel), 32'h0F7);
      chk("slot3_seg", 32'(seg_out), 32'h012);

      // Write to the lit digit is held off until its slot ends
      wr_valid = 1'b1; wr_addr = 3'd3; wr_data = 4'h9; wr_blank = 1'b0;
      held = 0;
      acc  = 1'b0;
      for (int k = 0; k < 20 && !acc; k++) begin
         step(acc);
         if (!acc) held++;
      end
      wr_valid = 1'b0;
      chk("held_cycles", 32'(held), 32'd4);
      seek_show(3);
      chk("slot3_new_sel", 32'(digit_sel), 32'h0F7);
      chk("slot3_new_seg", 32'(seg_out), 32'h010);

      // Walk all eight digits across two frames
      scan_en = 1'b0;
      tick();
      for (int i = 0; i < NDIG; i++) begin
         wr_valid = 1'b1; wr_addr = vecs[i].addr; wr_data = vecs[i].data; wr_blank = vecs[i].blank;
         tick();
      end
      wr_valid = 1'b0;
      scan_en  = 1'b1;
      for (int f = 0; f < 2; f++) begin
         for (int i = 0; i < NDIG; i++) begin
            repeat (GAP) begin
               tick();
               chk("walk_gap_sel", 32'(digit_sel), 32'h0FF);
            end
            repeat (SHOW) begin
               tick();
               chk("walk_sel", 32'(digit_sel), 32'(vecs[i].exp_sel));
               chk("walk_seg", 32'(seg_out), 32'(vecs[i].exp_seg));
            end
         end
      end

      // Drop scan_en mid-SHOW of digit 5, then restart at digit 0
      seek_show(5);
      tick();
      scan_en = 1'b0;
      tick();
      chk("drop_sel", 32'(digit_sel), 32'h0FF);
      chk("drop_seg", 32'(seg_out), 32'h07F);
      scan_en = 1'b1;
      tick();
      chk("restart_gap_sel", 32'(digit_sel), 32'h0FF);
      tick();
      chk("restart_sel", 32'(digit_sel), 32'h0FE);
      chk("restart_seg", 32'(seg_out), 32'h040);

      // Asynchronous reset mid-SHOW
      #1 rst_n = 1'b0;
      #1;
      chk("arst_sel", 32'(digit_sel), 32'h0FF);
      chk("arst_seg", 32'(seg_out), 32'h07F);
      chk("arst_ready", 32'(wr_ready), 32'h1);
      chk("arst_dec_b", 32'(dec_b), 32'h0);
      @(negedge clk) rst_n = 1'b1;
      model_reset();
      repeat (FRAME + 2) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
